// File: rtl/ctrl_pkg.sv
// Shared constants for the CHARIS multicycle controller: opcodes, state encoding,
// ALU function codes, immediate-extension selects and the opcode class record.
package ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b100000;
  localparam logic [5:0] OpLi    = 6'b111000;
  localparam logic [5:0] OpLui   = 6'b111001;
  localparam logic [5:0] OpAddi  = 6'b110000;
  localparam logic [5:0] OpAndi  = 6'b110010;
  localparam logic [5:0] OpOri   = 6'b110011;
  localparam logic [5:0] OpB     = 6'b111111;
  localparam logic [5:0] OpBeq   = 6'b000000;
  localparam logic [5:0] OpBne   = 6'b000001;
  localparam logic [5:0] OpLb    = 6'b000011;
  localparam logic [5:0] OpLw    = 6'b001111;
  localparam logic [5:0] OpSb    = 6'b000111;
  localparam logic [5:0] OpSw    = 6'b011111;

  localparam logic [3:0] StIf   = 4'd0;
  localparam logic [3:0] StDec  = 4'd1;
  localparam logic [3:0] StEx   = 4'd2;
  localparam logic [3:0] StWb   = 4'd3;
  localparam logic [3:0] StAddr = 4'd4;
  localparam logic [3:0] StMrd  = 4'd5;
  localparam logic [3:0] StWbm  = 4'd6;
  localparam logic [3:0] StMwr  = 4'd7;
  localparam logic [3:0] StCmp  = 4'd8;
  localparam logic [3:0] StBr   = 4'd9;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;

  localparam logic [1:0] ImmSext   = 2'b00;
  localparam logic [1:0] ImmZext   = 2'b01;
  localparam logic [1:0] ImmHi16   = 2'b10;
  localparam logic [1:0] ImmSextX4 = 2'b11;

  typedef struct packed {
    logic is_rtype;
    logic is_imm;
    logic is_load;
    logic is_store;
    logic is_beq;
    logic is_bne;
    logic is_b;
    logic is_byte;
    logic illegal;
  } op_class_t;

  function automatic logic [1:0] imm_ext_sel(logic [5:0] op);
    case (op)
      OpAndi, OpOri:    return ImmZext;
      OpLui:            return ImmHi16;
      OpBeq, OpBne, OpB: return ImmSextX4;
      default:          return ImmSext;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu_func(logic [5:0] op);
    case (op)
      OpAndi:  return AluAnd;
      OpOri:   return AluOr;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; anything not in the opcode table is flagged illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output op_class_t  cls_o
);

  always_comb begin
    cls_o = '0;
    unique case (opcode_i)
      OpRtype:                        cls_o.is_rtype = 1'b1;
      OpLi, OpLui, OpAddi, OpAndi, OpOri: cls_o.is_imm = 1'b1;
      OpLw:                           cls_o.is_load  = 1'b1;
      OpLb: begin
        cls_o.is_load = 1'b1;
        cls_o.is_byte = 1'b1;
      end
      OpSw:                           cls_o.is_store = 1'b1;
      OpSb: begin
        cls_o.is_store = 1'b1;
        cls_o.is_byte  = 1'b1;
      end
      OpBeq:                          cls_o.is_beq   = 1'b1;
      OpBne:                          cls_o.is_bne   = 1'b1;
      OpB:                            cls_o.is_b     = 1'b1;
      default:                        cls_o.illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle controller for the CHARIS datapath: one instruction at a time through
// fetch, decode, execute/address/compare, memory and write-back.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ALU_FUNC_W = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     Instr,
  input  logic                  ALU_zero,
  output logic                  IR_LdEn,
  output logic                  PC_LdEn,
  output logic                  PC_sel,
  output logic                  RF_WrEn,
  output logic                  RF_WrData_sel,
  output logic                  RF_B_sel,
  output logic [1:0]            ImmExt,
  output logic                  ALU_Bin_sel,
  output logic [ALU_FUNC_W-1:0] ALU_func,
  output logic                  MEM_WrEn,
  output logic                  ByteOp,
  output logic                  Instr_done
);

  logic [3:0] state_q, state_d;
  logic [5:0] opcode;
  op_class_t  cls;
  logic       unused_instr;

  assign opcode       = Instr[DATA_W-1 -: 6];
  assign unused_instr = ^Instr[DATA_W-7:ALU_FUNC_W];

  ctrl_decode u_decode (
    .opcode_i (opcode),
    .cls_o    (cls)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf:  state_d = StDec;
      StDec: begin
        if (cls.is_rtype || cls.is_imm)        state_d = StEx;
        else if (cls.is_load || cls.is_store)  state_d = StAddr;
        else if (cls.is_beq || cls.is_bne)     state_d = StCmp;
        else if (cls.is_b)                     state_d = StBr;
        else                                   state_d = StIf;
      end
      StEx:   state_d = StWb;
      StAddr: state_d = cls.is_load ? StMrd : StMwr;
      StMrd:  state_d = StWbm;
      default: state_d = StIf;
    endcase
  end

  // Reset forces every output low, so an in-flight instruction cannot write anything.
  always_comb begin
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ImmExt        = ImmSext;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_FUNC_W'(AluAdd);
    MEM_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Instr_done    = 1'b0;
    if (!Reset) begin
      RF_B_sel = cls.is_store | cls.is_beq | cls.is_bne;
      case (state_q)
        StIf: IR_LdEn = 1'b1;
        StDec: begin
          ImmExt = imm_ext_sel(opcode);
          if (cls.illegal) begin
            PC_LdEn    = 1'b1;
            Instr_done = 1'b1;
          end
        end
        StEx, StWb: begin
          // ALU controls stay put through write-back so ALU_out is stable.
          ImmExt      = imm_ext_sel(opcode);
          ALU_Bin_sel = cls.is_imm;
          ALU_func    = cls.is_rtype ? Instr[ALU_FUNC_W-1:0]
                                     : ALU_FUNC_W'(imm_alu_func(opcode));
          if (state_q == StWb) begin
            RF_WrEn    = 1'b1;
            PC_LdEn    = 1'b1;
            Instr_done = 1'b1;
          end
        end
        StAddr, StMrd: begin
          ALU_Bin_sel = 1'b1;
          ByteOp      = cls.is_byte;
        end
        StWbm: begin
          ALU_Bin_sel   = 1'b1;
          ByteOp        = cls.is_byte;
          RF_WrEn       = 1'b1;
          RF_WrData_sel = 1'b1;
          PC_LdEn       = 1'b1;
          Instr_done    = 1'b1;
        end
        StMwr: begin
          ALU_Bin_sel = 1'b1;
          ByteOp      = cls.is_byte;
          MEM_WrEn    = 1'b1;
          PC_LdEn     = 1'b1;
          Instr_done  = 1'b1;
        end
        StCmp: begin
          ALU_func   = ALU_FUNC_W'(AluSub);
          ImmExt     = ImmSextX4;
          PC_LdEn    = 1'b1;
          PC_sel     = cls.is_beq ? ALU_zero : ~ALU_zero;
          Instr_done = 1'b1;
        end
        StBr: begin
          ImmExt     = ImmSextX4;
          PC_LdEn    = 1'b1;
          PC_sel     = 1'b1;
          Instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed table, reset corner cases and random
// instruction streams checked per cycle against a per-instruction cycle model.
module tb_multicycle_control_fsm;

  localparam logic [5:0] T_R = 6'b100000, T_LI = 6'b111000, T_LUI = 6'b111001;
  localparam logic [5:0] T_ADDI = 6'b110000, T_ANDI = 6'b110010, T_ORI = 6'b110011;
  localparam logic [5:0] T_B = 6'b111111, T_BEQ = 6'b000000, T_BNE = 6'b000001;
  localparam logic [5:0] T_LB = 6'b000011, T_LW = 6'b001111, T_SB = 6'b000111;
  localparam logic [5:0] T_SW = 6'b011111;

  typedef struct packed {
    logic       ir;
    logic       pcld;
    logic       pcsel;
    logic       rfwr;
    logic       wdsel;
    logic       rfb;
    logic [1:0] immext;
    logic       binsel;
    logic [3:0] func;
    logic       memwr;
    logic       byteop;
    logic       done;
  } out_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    int          cycles;
    out_t        last;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr = '0;
  logic        ALU_zero = 1'b0;
  logic        IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic [1:0]  ImmExt;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        MEM_WrEn, ByteOp, Instr_done;
  out_t        act;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  multicycle_control_fsm dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .ALU_zero      (ALU_zero),
    .IR_LdEn       (IR_LdEn),
    .PC_LdEn       (PC_LdEn),
    .PC_sel        (PC_sel),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ImmExt        (ImmExt),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .MEM_WrEn      (MEM_WrEn),
    .ByteOp        (ByteOp),
    .Instr_done    (Instr_done)
  );

  assign act = {IR_LdEn, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt,
                ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp, Instr_done};

  task automatic check(input string name, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int n_cycles(input logic [5:0] op);
    case (op)
      T_R, T_LI, T_LUI, T_ADDI, T_ANDI, T_ORI, T_SB, T_SW: return 4;
      T_LB, T_LW:                                         return 5;
      T_BEQ, T_BNE, T_B:                                  return 3;
      default:                                            return 2;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = fetch) of the instruction.
  function automatic out_t model(input logic [31:0] ins, input logic z, input int k);
    logic [5:0] op = ins[31:26];
    out_t e = '0;
    bit imm = (op == T_LI) || (op == T_LUI) || (op == T_ADDI) || (op == T_ANDI) ||
              (op == T_ORI);
    bit alu = imm || (op == T_R);
    bit load = (op == T_LB) || (op == T_LW);
    bit store = (op == T_SB) || (op == T_SW);
    bit br2 = (op == T_BEQ) || (op == T_BNE);
    bit last = (k == n_cycles(op) - 1);
    logic [1:0] ie = (op == T_ANDI || op == T_ORI) ? 2'b01 :
                     (op == T_LUI) ? 2'b10 : (br2 || op == T_B) ? 2'b11 : 2'b00;
    e.rfb = store || br2;
    if (k == 0) begin
      e.ir = 1'b1;
    end else if (k == 1) begin
      e.immext = ie;
    end else if (alu) begin
      e.immext = ie;
      e.binsel = imm;
      e.func   = (op == T_R) ? ins[3:0] : (op == T_ANDI) ? 4'd2 : (op == T_ORI) ? 4'd3 : 4'd0;
      e.rfwr   = last;
    end else if (load || store) begin
      e.binsel = 1'b1;
      e.byteop = (op == T_LB) || (op == T_SB);
      e.rfwr   = load && last;
      e.wdsel  = load && last;
      e.memwr  = store && last;
    end else if (br2) begin
      e.func   = 4'd1;
      e.immext = 2'b11;
      e.pcsel  = (op == T_BEQ) ? z : !z;
    end else begin
      e.immext = 2'b11;
      e.pcsel  = 1'b1;
    end
    if (last) begin
      e.pcld = 1'b1;
      e.done = 1'b1;
    end
    return e;
  endfunction

  // Entered just after the edge that puts the DUT in fetch; zmode 2 randomises ALU_zero.
  task automatic run_instr(input string tag, input logic [31:0] ins, input int ncyc,
                           input int zmode, output out_t last);
    Instr = ins;
    last  = '0;
    for (int k = 0; k < ncyc; k++) begin
      ALU_zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      @(negedge Clk);
      check($sformatf("%s_c%0d", tag, k), act, model(ins, ALU_zero, k));
      last = act;
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag, input int ncyc);
    Reset = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge Clk);
      check($sformatf("%s_rst%0d", tag, k), act, out_t'(0));
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
  endtask

  function automatic out_t fin(input logic pcsel, input logic rfwr, input logic wd,
                               input logic rfb, input logic [1:0] ie, input logic bin,
                               input logic [3:0] fn, input logic mw, input logic bo);
    out_t e = '0;
    e.pcld = 1'b1; e.done = 1'b1; e.pcsel = pcsel; e.rfwr = rfwr; e.wdsel = wd;
    e.rfb = rfb; e.immext = ie; e.binsel = bin; e.func = fn; e.memwr = mw; e.byteop = bo;
    return e;
  endfunction

  initial begin
    vec_t tbl[$];
    out_t last;
    logic [5:0] legal[13] = '{T_R, T_LI, T_LUI, T_ADDI, T_ANDI, T_ORI, T_B, T_BEQ, T_BNE,
                              T_LB, T_LW, T_SB, T_SW};

    tbl.push_back('{"add",    32'h8062_0030, 1'b0, 4, fin(0, 1, 0, 0, 2'b00, 0, 4'h0, 0, 0)});
    tbl.push_back('{"sub",    32'h8062_0031, 1'b0, 4, fin(0, 1, 0, 0, 2'b00, 0, 4'h1, 0, 0)});
    tbl.push_back('{"ror",    32'h8062_003d, 1'b1, 4, fin(0, 1, 0, 0, 2'b00, 0, 4'hd, 0, 0)});
    tbl.push_back('{"addi",   32'hC000_1235, 1'b0, 4, fin(0, 1, 0, 0, 2'b00, 1, 4'h0, 0, 0)});
    tbl.push_back('{"andi",   32'hC800_1233, 1'b0, 4, fin(0, 1, 0, 0, 2'b01, 1, 4'h2, 0, 0)});
    tbl.push_back('{"ori",    32'hCC00_1231, 1'b0, 4, fin(0, 1, 0, 0, 2'b01, 1, 4'h3, 0, 0)});
    tbl.push_back('{"lui",    32'hE400_1237, 1'b0, 4, fin(0, 1, 0, 0, 2'b10, 1, 4'h0, 0, 0)});
    tbl.push_back('{"li",     32'hE000_1238, 1'b0, 4, fin(0, 1, 0, 0, 2'b00, 1, 4'h0, 0, 0)});
    tbl.push_back('{"lw",     32'h3C22_0004, 1'b0, 5, fin(0, 1, 1, 0, 2'b00, 1, 4'h0, 0, 0)});
    tbl.push_back('{"lb",     32'h0C22_0004, 1'b0, 5, fin(0, 1, 1, 0, 2'b00, 1, 4'h0, 0, 1)});
    tbl.push_back('{"sw",     32'h7C22_0004, 1'b0, 4, fin(0, 0, 0, 1, 2'b00, 1, 4'h0, 1, 0)});
    tbl.push_back('{"sb",     32'h1C22_0004, 1'b0, 4, fin(0, 0, 0, 1, 2'b00, 1, 4'h0, 1, 1)});
    tbl.push_back('{"beq_z1", 32'h0022_0010, 1'b1, 3, fin(1, 0, 0, 1, 2'b11, 0, 4'h1, 0, 0)});
    tbl.push_back('{"beq_z0", 32'h0022_0010, 1'b0, 3, fin(0, 0, 0, 1, 2'b11, 0, 4'h1, 0, 0)});
    tbl.push_back('{"bne_z1", 32'h0422_0010, 1'b1, 3, fin(0, 0, 0, 1, 2'b11, 0, 4'h1, 0, 0)});
    tbl.push_back('{"bne_z0", 32'h0422_0010, 1'b0, 3, fin(1, 0, 0, 1, 2'b11, 0, 4'h1, 0, 0)});
    tbl.push_back('{"b",      32'hFC00_0010, 1'b0, 3, fin(1, 0, 0, 0, 2'b11, 0, 4'h0, 0, 0)});
    tbl.push_back('{"illegal", 32'h5462_0030, 1'b0, 2, fin(0, 0, 0, 0, 2'b00, 0, 4'h0, 0, 0)});

    do_reset("init", 2);

    foreach (tbl[i]) begin
      run_instr(tbl[i].name, tbl[i].instr, tbl[i].cycles, tbl[i].zero ? 1 : 0, last);
      check({tbl[i].name, "_final"}, last, tbl[i].last);
    end

    // Reset while lw sits in its memory-read cycle: nothing may be written.
    Instr = {T_LW, 26'h022_0004};
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check($sformatf("lw_abort_c%0d", k), act, model(Instr, ALU_zero, k));
      @(posedge Clk);
      #1;
    end
    do_reset("lw_abort", 1);
    run_instr("after_abort", 32'h8062_0030, 4, 0, last);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op = legal[$urandom_range(0, 12)];
      if ($urandom_range(0, 9) == 0) begin
        do begin
          op = 6'($urandom_range(0, 63));
        end while (n_cycles(op) != 2 || op == T_R);
      end
      run_instr($sformatf("rnd%0d", n), {op, 26'($urandom)}, n_cycles(op), 2, last);
      if ($urandom_range(0, 29) == 0) do_reset($sformatf("rnd%0d", n), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
